// File: rtl/iob_eth_lb_pkg.sv
// iob_eth_lb_pkg
// Shared constants for the Ethernet loopback generator: capture and replay
// state encodings, default line-rate constants and the frame length width.
// Optional feature macro used by the top: ETH_LB_ERR_INJ_EN.

package iob_eth_lb_pkg;

    // Capture FSM encodings
    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_CAP  = 2'd1;
    localparam logic [1:0] C_DROP = 2'd2;

    // Replay FSM encodings
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_GAP  = 2'd1;
    localparam logic [1:0] R_SEND = 2'd2;

    localparam int DEF_IFG     = 24;
    localparam int DEF_CLK_DIV = 4;

    // A frame may fill the whole buffer, so lengths need one bit more than
    // the buffer address.
    function automatic int len_w(input int buf_aw);
        return buf_aw + 1;
    endfunction

endpackage

// File: rtl/iob_eth_lb_clkgen.sv
// iob_eth_lb_clkgen
// Divides clk by CLK_DIV to produce the Ethernet line clock and two
// single-cycle strobes aligned to its edges.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   eth_clk_o     registered line clock, 50% duty
//   sample_ce_o   high for the clk cycle that ends on the eth_clk falling edge
//   drive_ce_o    high for the clk cycle that ends on the eth_clk rising edge

module iob_eth_lb_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic eth_clk_o,
    output logic sample_ce_o,
    output logic drive_ce_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] DRV  = CW'(CLK_DIV / 2 - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          eth_clk_q, eth_clk_d;
    logic          sample_ce_q, sample_ce_d;
    logic          drive_ce_q, drive_ce_d;

    // The strobes are registered from the same count that feeds eth_clk, so
    // a flop enabled by a strobe updates on the same clk edge where eth_clk
    // toggles.
    always_comb begin
        div_cnt_d   = (div_cnt_q == LAST) ? '0 : div_cnt_q + CW'(1);
        eth_clk_d   = (div_cnt_q >= HALF);
        sample_ce_d = (div_cnt_q == LAST);
        drive_ce_d  = (div_cnt_q == DRV);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            eth_clk_q   <= 1'b0;
            sample_ce_q <= 1'b0;
            drive_ce_q  <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            eth_clk_q   <= eth_clk_d;
            sample_ce_q <= sample_ce_d;
            drive_ce_q  <= drive_ce_d;
        end
    end

    assign eth_clk_o   = eth_clk_q;
    assign sample_ce_o = sample_ce_q;
    assign drive_ce_o  = drive_ce_q;

endmodule

// File: rtl/iob_eth_lb_gen.sv
// iob_eth_lb_gen
// MII-style loopback: captures whole frames from the core's TX side into a
// circular frame buffer and replays each on the core's RX side after an
// inter-frame gap. Frames that do not fit are dropped whole.
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   en_i                     low stops new captures; current work completes
//   eth_clk_o                generated line clock (core RX_CLK and TX_CLK)
//   lb_rx_data_i/lb_rx_dv_i  from core TX_DATA / TX_EN
//   lb_tx_data_o/lb_tx_en_o  to core RX_DATA / RX_DV
//   frames_fwd_o             frames fully replayed (wraps)
//   frames_drop_o            frames dropped (wraps)
//   busy_o                   capture, replay or gap in progress, or frames pending
//   err_inj_i, err_idx_i     only with ETH_LB_ERR_INJ_EN: arm a one-shot
//                            inversion of entry err_idx_i of the next frame
//
// Capture FSM (advances on sample_ce)
//   state  | meaning
//   C_IDLE | waiting for dv with enable set
//   C_CAP  | writing a frame into the buffer
//   C_DROP | discarding the rest of a frame that did not fit
// Replay FSM (advances on drive_ce)
//   state  | meaning
//   R_IDLE | waiting for a committed frame; first entry goes out on pop
//   R_SEND | driving the remaining entries of a frame
//   R_GAP  | IFG idle ticks; also the reset state

module iob_eth_lb_gen
    import iob_eth_lb_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int BUF_AW  = 11,
    parameter int LEN_AW  = 2,
    parameter int IFG     = DEF_IFG,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
`ifdef ETH_LB_ERR_INJ_EN
    input  logic              err_inj_i,
    input  logic [BUF_AW-1:0] err_idx_i,
`endif
    output logic              eth_clk_o,
    input  logic [DATA_W-1:0] lb_rx_data_i,
    input  logic              lb_rx_dv_i,
    output logic [DATA_W-1:0] lb_tx_data_o,
    output logic              lb_tx_en_o,
    output logic [CNT_W-1:0]  frames_fwd_o,
    output logic [CNT_W-1:0]  frames_drop_o,
    output logic              busy_o
);

    localparam int LW = len_w(BUF_AW);
    localparam int GW = $clog2(IFG + 1);
    localparam logic [LW-1:0] FULL_CNT = {1'b1, {BUF_AW{1'b0}}};
    localparam logic [LEN_AW:0] LF_FULL = {1'b1, {LEN_AW{1'b0}}};

    logic sample_ce, drive_ce;

    iob_eth_lb_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk         (clk),
        .rst         (rst),
        .eth_clk_o   (eth_clk_o),
        .sample_ce_o (sample_ce),
        .drive_ce_o  (drive_ce)
    );

    // Frame buffer: one write port (capture), one registered read port (replay)
    logic [DATA_W-1:0] mem [2**BUF_AW];
    logic [DATA_W-1:0] rd_data_q;
    logic              mem_we;

    // Pending-frame length FIFO
    logic [LW-1:0]     lfifo [2**LEN_AW];
    logic [LEN_AW:0]   lf_wr_q, lf_wr_d, lf_rd_q, lf_rd_d;
    logic              lf_push, lf_pop, lf_full, lf_empty;
    logic [LW-1:0]     lf_head;

    // Capture state
    logic [1:0]        cap_st_q, cap_st_d;
    logic [LW-1:0]     wr_ptr_q, wr_ptr_d, wr_start_q, wr_start_d;
    logic [LW-1:0]     cap_len_q, cap_len_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              buf_full;

    // Replay state
    logic [1:0]        rep_st_q, rep_st_d;
    logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     rem_q, rem_d, rem_cur;
    logic [LW-1:0]     idx_q, idx_d, idx_cur;
    logic [GW-1:0]     gap_q, gap_d;
    logic [CNT_W-1:0]  fwd_cnt_q, fwd_cnt_d;
    logic              tx_en_q, tx_en_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              busy_q, busy_d;
    logic              frame_start, sending, frame_end, inj_hit;

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[BUF_AW-1:0]] <= lb_rx_data_i;
        rd_data_q <= mem[rd_ptr_q[BUF_AW-1:0]];
        if (lf_push) lfifo[lf_wr_q[LEN_AW-1:0]] <= cap_len_q;
    end

    assign lf_full  = ((lf_wr_q ^ lf_rd_q) == LF_FULL);
    assign lf_empty = (lf_wr_q == lf_rd_q);
    assign lf_head  = lfifo[lf_rd_q[LEN_AW-1:0]];
    // Read pointer already advanced past replayed entries, so space frees
    // up while a frame is still being sent.
    assign buf_full = ((wr_ptr_q - rd_ptr_q) == FULL_CNT);

    always_comb begin
        cap_st_d   = cap_st_q;
        wr_ptr_d   = wr_ptr_q;
        wr_start_d = wr_start_q;
        cap_len_d  = cap_len_q;
        drop_cnt_d = drop_cnt_q;
        mem_we     = 1'b0;
        lf_push    = 1'b0;
        if (sample_ce) begin
            case (cap_st_q)
                C_IDLE: begin
                    if (lb_rx_dv_i && en_i) begin
                        if (lf_full || buf_full) begin
                            cap_st_d = C_DROP;
                        end else begin
                            mem_we    = 1'b1;
                            wr_ptr_d  = wr_ptr_q + LW'(1);
                            cap_len_d = LW'(1);
                            cap_st_d  = C_CAP;
                        end
                    end
                end
                C_CAP: begin
                    if (lb_rx_dv_i) begin
                        if (buf_full) begin
                            wr_ptr_d = wr_start_q;
                            cap_st_d = C_DROP;
                        end else begin
                            mem_we    = 1'b1;
                            wr_ptr_d  = wr_ptr_q + LW'(1);
                            cap_len_d = cap_len_q + LW'(1);
                        end
                    end else begin
                        lf_push    = 1'b1;
                        wr_start_d = wr_ptr_q;
                        cap_st_d   = C_IDLE;
                    end
                end
                C_DROP: begin
                    if (!lb_rx_dv_i) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                        cap_st_d   = C_IDLE;
                    end
                end
                default: cap_st_d = C_IDLE;
            endcase
        end
    end

    // The first entry leaves on the same tick the length is popped, so the
    // line sees exactly IFG idle ticks between back-to-back frames.
    assign frame_start = drive_ce && (rep_st_q == R_IDLE) && !lf_empty;
    assign sending     = frame_start || (drive_ce && (rep_st_q == R_SEND));
    assign rem_cur     = (rep_st_q == R_IDLE) ? lf_head : rem_q;
    assign idx_cur     = (rep_st_q == R_IDLE) ? '0 : idx_q;
    assign frame_end   = sending && (rem_cur == LW'(1));

`ifdef ETH_LB_ERR_INJ_EN
    logic arm_q, arm_d, act_q, act_d, act_cur;

    // A pulse coinciding with a frame start stays armed for the next frame.
    always_comb begin
        arm_d   = arm_q | err_inj_i;
        act_d   = act_q;
        act_cur = frame_start ? arm_q : act_q;
        if (frame_start) begin
            arm_d = err_inj_i;
            act_d = arm_q;
        end
        if (frame_end) act_d = 1'b0;
        inj_hit = sending && act_cur && (idx_cur == LW'(err_idx_i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q <= 1'b0;
            act_q <= 1'b0;
        end else begin
            arm_q <= arm_d;
            act_q <= act_d;
        end
    end
`else
    assign inj_hit = 1'b0;
`endif

    always_comb begin
        rep_st_d  = rep_st_q;
        rd_ptr_d  = rd_ptr_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        fwd_cnt_d = fwd_cnt_q;
        tx_en_d   = tx_en_q;
        tx_data_d = tx_data_q;
        lf_pop    = frame_start;
        if (drive_ce) begin
            tx_en_d   = 1'b0;
            tx_data_d = '0;
            if (rep_st_q == R_GAP) begin
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) rep_st_d = R_IDLE;
            end
            if (sending) begin
                tx_en_d   = 1'b1;
                tx_data_d = rd_data_q ^ {DATA_W{inj_hit}};
                rd_ptr_d  = rd_ptr_q + LW'(1);
                rem_d     = rem_cur - LW'(1);
                idx_d     = idx_cur + LW'(1);
                rep_st_d  = R_SEND;
                if (frame_end) begin
                    fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
                    gap_d     = GW'(IFG);
                    rep_st_d  = R_GAP;
                end
            end
        end
        lf_wr_d = lf_wr_q + {{LEN_AW{1'b0}}, lf_push};
        lf_rd_d = lf_rd_q + {{LEN_AW{1'b0}}, lf_pop};
        busy_d  = (cap_st_q != C_IDLE) || (rep_st_q != R_IDLE) || !lf_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_st_q   <= C_IDLE;
            wr_ptr_q   <= '0;
            wr_start_q <= '0;
            cap_len_q  <= '0;
            drop_cnt_q <= '0;
            lf_wr_q    <= '0;
            lf_rd_q    <= '0;
            rep_st_q   <= R_GAP;
            rd_ptr_q   <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            gap_q      <= GW'(IFG);
            fwd_cnt_q  <= '0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            cap_st_q   <= cap_st_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_start_q <= wr_start_d;
            cap_len_q  <= cap_len_d;
            drop_cnt_q <= drop_cnt_d;
            lf_wr_q    <= lf_wr_d;
            lf_rd_q    <= lf_rd_d;
            rep_st_q   <= rep_st_d;
            rd_ptr_q   <= rd_ptr_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            fwd_cnt_q  <= fwd_cnt_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign lb_tx_en_o    = tx_en_q;
    assign lb_tx_data_o  = tx_data_q;
    assign frames_fwd_o  = fwd_cnt_q;
    assign frames_drop_o = drop_cnt_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_iob_eth_lb_gen.sv
module tb_iob_eth_lb_gen;

    localparam int DATA_W  = 4;
    localparam int CLK_DIV = 4;
    localparam int BUF_AW  = 4;
    localparam int LEN_AW  = 1;
    localparam int IFG     = 24;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en_i = 1'b0;
    logic              eth_clk_o;
    logic [DATA_W-1:0] lb_rx_data_i = '0;
    logic              lb_rx_dv_i = 1'b0;
    logic [DATA_W-1:0] lb_tx_data_o;
    logic              lb_tx_en_o;
    logic [CNT_W-1:0]  frames_fwd_o;
    logic [CNT_W-1:0]  frames_drop_o;
    logic              busy_o;
`ifdef ETH_LB_ERR_INJ_EN
    logic              err_inj_i = 1'b0;
    logic [BUF_AW-1:0] err_idx_i = '0;
`endif

    iob_eth_lb_gen #(
        .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .BUF_AW(BUF_AW),
        .LEN_AW(LEN_AW), .IFG(IFG), .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_i),
`ifdef ETH_LB_ERR_INJ_EN
        .err_inj_i     (err_inj_i),
        .err_idx_i     (err_idx_i),
`endif
        .eth_clk_o     (eth_clk_o),
        .lb_rx_data_i  (lb_rx_data_i),
        .lb_rx_dv_i    (lb_rx_dv_i),
        .lb_tx_data_o  (lb_tx_data_o),
        .lb_tx_en_o    (lb_tx_en_o),
        .frames_fwd_o  (frames_fwd_o),
        .frames_drop_o (frames_drop_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q[$];
    int         idle_cnt = 0;
    int         last_gap = 0;
    bit         in_frame = 1'b0;
    bit         mon_off  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one nibble per eth clock, changing right after the rising edge.
    // The expected replay is pushed as the stimulus goes out.
    task automatic send_frame(input int n, input int start, input int step,
                              input bit fwd, input int inj_idx);
        logic [3:0] v;
        for (int i = 0; i < n; i++) begin
            v = 4'(start + i * step);
            @(posedge eth_clk_o);
            @(negedge clk);
            lb_rx_dv_i   = 1'b1;
            lb_rx_data_i = v;
            if (fwd) exp_q.push_back((i == inj_idx) ? ~v : v);
        end
        @(posedge eth_clk_o);
        @(negedge clk);
        lb_rx_dv_i   = 1'b0;
        lb_rx_data_i = '0;
    endtask

    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || busy_o) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(cyc < 4000), 32'd1);
    endtask

    // Output monitor: compares every replayed nibble against the scoreboard
    // and records the idle ticks preceding each frame.
    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(posedge eth_clk_o);
            @(negedge clk);
            if (mon_off) begin
                in_frame = 1'b0;
                idle_cnt = 0;
            end else if (lb_tx_en_o) begin
                if (!in_frame) begin
                    last_gap = idle_cnt;
                    in_frame = 1'b1;
                end
                idle_cnt = 0;
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rx_nibble", 32'(lb_tx_data_o), 32'(e));
                end
            end else begin
                in_frame = 1'b0;
                idle_cnt++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         k;
        logic [7:0] pat;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_eth_clk", 32'(eth_clk_o), 32'd0);
        check("rst_tx_en", 32'(lb_tx_en_o), 32'd0);
        check("rst_tx_data", 32'(lb_tx_data_o), 32'd0);
        check("rst_fwd", 32'(frames_fwd_o), 32'd0);
        check("rst_drop", 32'(frames_drop_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);

        // Divider: first high on the 3rd clk, then 2 high / 2 low
        en_i = 1'b1;
        rst  = 1'b0;
        k    = 0;
        for (int i = 1; i <= 10 && k == 0; i++) begin
            @(posedge clk);
            #1;
            if (eth_clk_o) k = i;
        end
        check("eth_clk_first_high", 32'(k), 32'd3);
        pat = {7'd0, eth_clk_o};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            pat = {pat[6:0], eth_clk_o};
        end
        check("eth_clk_pattern", 32'(pat), 32'hCC);

        // Length FIFO depth 2: three frames land during the post-reset gap
        send_frame(2, 1, 1, 1'b1, -1);
        send_frame(2, 3, 1, 1'b1, -1);
        send_frame(2, 5, 1, 1'b0, -1);
        wait_drain("drain_lenfifo");
        check("lenfifo_fwd", 32'(frames_fwd_o), 32'd2);
        check("lenfifo_drop", 32'(frames_drop_o), 32'd1);

        // Re-reset clears counters
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rerst_fwd", 32'(frames_fwd_o), 32'd0);
        check("rerst_drop", 32'(frames_drop_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full-buffer frame 0x0..0xF
        send_frame(16, 0, 1, 1'b1, -1);
        wait_drain("drain_16");
        check("f16_gap_ge_ifg", 32'(last_gap >= IFG), 32'd1);
        check("f16_fwd", 32'(frames_fwd_o), 32'd1);
        check("f16_drop", 32'(frames_drop_o), 32'd0);

        // Back-to-back 8 and 5 nibble frames, one idle tick apart
        send_frame(8, 3, 1, 1'b1, -1);
        send_frame(5, 9, 2, 1'b1, -1);
        wait_drain("drain_b2b");
        check("b2b_gap", 32'(last_gap), 32'(IFG));
        check("b2b_fwd", 32'(frames_fwd_o), 32'd3);

        // Oversize frame dropped, following frame intact
        send_frame(20, 0, 1, 1'b0, -1);
        send_frame(3, 10, 1, 1'b1, -1);
        wait_drain("drain_ovf");
        check("ovf_drop", 32'(frames_drop_o), 32'd1);
        check("ovf_fwd", 32'(frames_fwd_o), 32'd4);

`ifdef ETH_LB_ERR_INJ_EN
        @(negedge clk);
        err_idx_i = 4'd2;
        err_inj_i = 1'b1;
        @(negedge clk);
        err_inj_i = 1'b0;
        send_frame(6, 5, 0, 1'b1, 2);
        send_frame(6, 5, 0, 1'b1, -1);
        wait_drain("drain_inj");
        check("inj_fwd", 32'(frames_fwd_o), 32'd6);
`endif

        // Reset in the middle of a replay
        send_frame(10, 0, 1, 1'b1, -1);
        k = 0;
        while (!lb_tx_en_o && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("midrst_replay_started", 32'(lb_tx_en_o), 32'd1);
        mon_off = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_tx_en", 32'(lb_tx_en_o), 32'd0);
        check("midrst_tx_data", 32'(lb_tx_data_o), 32'd0);
        check("midrst_fwd", 32'(frames_fwd_o), 32'd0);
        check("midrst_eth_clk", 32'(eth_clk_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
